axil_reg_responder: RTL
=======================

Name: axil_reg_responder

Overview:
AXI4-Lite slave (responder) that terminates the shell's control-register path for the user plugin. It accepts writes and reads on the same AXI4-Lite channel set the bench and host drive, and holds a bank of RW control registers exported to the datapath. It also exposes a bank of RO status words sampled from the datapath. Unmapped or illegal accesses return error responses and never hang the bus.

Parameters:
ADDR_W, 32, AXI4-Lite address width
NUM_CTRL, 8, number of 32-bit RW control registers at offsets 0x000 + 4*i
NUM_STAT, 4, number of 32-bit RO status registers at offsets STAT_BASE + 4*j
STAT_BASE, 32'h100, byte offset of the status bank
ADDR_MASK, 32'h0000_0FFF, bits of the address used for decode; upper bits ignored

Ports:
axil_aclk  in  1  register clock
axil_aresetn  in  1  synchronous active-low reset
s_axil_awvalid  in  1  write address valid
s_axil_awaddr  in  ADDR_W  write address
s_axil_awready  out  1  write address ready
s_axil_wvalid  in  1  write data valid
s_axil_wdata  in  32  write data (full-word writes only, no strobes)
s_axil_wready  out  1  write data ready
s_axil_bvalid  out  1  write response valid
s_axil_bresp  out  2  write response
s_axil_bready  in  1  write response ready
s_axil_arvalid  in  1  read address valid
s_axil_araddr  in  ADDR_W  read address
s_axil_arready  out  1  read address ready
s_axil_rvalid  out  1  read data valid
s_axil_rdata  out  32  read data
s_axil_rresp  out  2  read response
s_axil_rready  in  1  read data ready
ctrl_regs  out  32*NUM_CTRL  control register contents; register i at bits [32i+31:32i]
ctrl_wr_pulse  out  NUM_CTRL  one-cycle pulse per register on a successful write
stat_in  in  32*NUM_STAT  status words; word j at bits [32j+31:32j]

Behaviour:
- Reset: synchronous, sampled on the axil_aclk rising edge while axil_aresetn=0. All outputs are 0 during reset: the readies, valids, resp, rdata, ctrl_regs and ctrl_wr_pulse. After release, awready=wready=arready=1 on the next cycle.
- Decode uses addr & ADDR_MASK. addr[1:0] is ignored, so accesses are word-aligned.
  - Control hit: offset < 4*NUM_CTRL.
  - Status hit: STAT_BASE <= offset < STAT_BASE + 4*NUM_STAT.
  - Anything else is unmapped.
- Write channel states: IDLE, HAVE_AW, HAVE_W, RESP.
  - AW and W are accepted independently and in either order.
  - awready=1 only in IDLE or HAVE_W. wready=1 only in IDLE or HAVE_AW.
  - The address and data are latched on their handshakes.
  - On the edge where the second of the two handshakes completes (or both, if in the same cycle), the write commits: the register updates, ctrl_wr_pulse[i]=1 for exactly that following cycle, bvalid=1, and the state moves to RESP.
  - Response codes: control hit gives bresp=2'b00. Status hit gives 2'b10 (SLVERR) with no state change and no pulse. Unmapped gives 2'b11 (DECERR) with no change.
  - RESP holds bvalid and bresp stable until bready=1. The state then returns to IDLE and the readies reassert the next cycle.
- Read channel states: IDLE, RESP.
  - arready=1 only in IDLE.
  - On the AR handshake edge, rdata/rresp are registered and rvalid=1.
  - Response codes: control hit returns the register value with 2'b00. Status hit returns stat_in sampled at the handshake cycle with 2'b00. Unmapped returns 32'hDEAD_BEEF with 2'b11.
  - rvalid, rdata and rresp hold until rready, then the channel returns to IDLE.
- Read and write channels are fully independent. A read handshake on the same edge as a write commit to the same register returns the pre-write value.
- Throughput: at most one write per 2 cycles (accept/commit, then response). Reads follow the same cadence.
- Reset mid-transaction: any pending AW/W/B/R is dropped, registers clear, and no response is issued after reset.

Test Plan:
- AW and W in the same cycle, addr 0x004, data 0x0000_0001, bready=1 → bvalid the next cycle with bresp=00; ctrl_regs[63:32]=0x1; ctrl_wr_pulse=8'b0000_0010 for 1 cycle.
- W 3 cycles before AW, addr 0x000, data 0xA5A5_5A5A, bready held 0 for 5 cycles → bvalid stays high with bresp=00 until bready; awready=wready=0 throughout.
- Read 0x104 with stat_in word1=0x1234_5678 → rvalid, rdata=0x1234_5678, rresp=00. Write 0x104 → bresp=10; readback is unchanged.
- Read 0x800 → rdata=0xDEAD_BEEF, rresp=11. Write 0x020 (NUM_CTRL=8) → bresp=11; no ctrl_wr_pulse.
- Write 0x008=0x7 committing on the same edge as an AR handshake for 0x008 (old 0x3) → rdata=0x3; a subsequent read returns 0x7.
- Assert axil_aresetn=0 while bvalid is pending for a write of 0xFFFF_FFFF to 0x00C → all outputs 0; after release ctrl_regs=0, bvalid=0, and awready/wready/arready=1.

Source files
------------

// File: rtl/axil_reg_responder_if.sv
// AXI4-Lite channel bundle between a host (master) and the register responder (slave).
//   master: drives AW/W/AR valid+payload and B/R ready
//   slave : drives AW/W/AR ready and B/R valid+response
interface axil_reg_responder_if #(
  parameter int unsigned ADDR_W = 32
) ();

  logic              awvalid;
  logic [ADDR_W-1:0] awaddr;
  logic              awready;
  logic              wvalid;
  logic [31:0]       wdata;
  logic              wready;
  logic              bvalid;
  logic [1:0]        bresp;
  logic              bready;
  logic              arvalid;
  logic [ADDR_W-1:0] araddr;
  logic              arready;
  logic              rvalid;
  logic [31:0]       rdata;
  logic [1:0]        rresp;
  logic              rready;

  modport master (
    output awvalid, awaddr, wvalid, wdata, bready, arvalid, araddr, rready,
    input  awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
  );

  modport slave (
    input  awvalid, awaddr, wvalid, wdata, bready, arvalid, araddr, rready,
    output awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
  );

endinterface

// File: rtl/axil_reg_responder.sv
// AXI4-Lite register responder: RW control bank exported to the datapath,
// RO status bank sampled from the datapath, error responses for everything else.
// Ports:
//   axil_aclk, axil_aresetn : clock, synchronous active-low reset
//   s_axil                  : AXI4-Lite slave channel set
//   ctrl_regs               : control register contents, register i at [32i+31:32i]
//   ctrl_wr_pulse           : one-cycle pulse per register on a successful write
//   stat_in                 : status words, word j at [32j+31:32j]
module axil_reg_responder #(
  parameter int unsigned      ADDR_W    = 32,
  parameter int unsigned      NUM_CTRL  = 8,
  parameter int unsigned      NUM_STAT  = 4,
  parameter int unsigned      STAT_BASE = 32'h100,
  parameter logic [ADDR_W-1:0] ADDR_MASK = ADDR_W'(32'h0000_0FFF)
) (
  input  logic                     axil_aclk,
  input  logic                     axil_aresetn,
  axil_reg_responder_if.slave      s_axil,
  output logic [32*NUM_CTRL-1:0]   ctrl_regs,
  output logic [NUM_CTRL-1:0]      ctrl_wr_pulse,
  input  logic [32*NUM_STAT-1:0]   stat_in
);

  localparam int unsigned       WORD_W     = ADDR_W - 2;
  localparam logic [WORD_W-1:0] CTRL_WORDS = WORD_W'(NUM_CTRL);
  localparam logic [WORD_W-1:0] STAT_LO    = WORD_W'(STAT_BASE / 4);
  localparam logic [WORD_W-1:0] STAT_HI    = WORD_W'(STAT_BASE / 4 + NUM_STAT);
  localparam logic [1:0]        RESP_OKAY   = 2'b00;
  localparam logic [1:0]        RESP_SLVERR = 2'b10;
  localparam logic [1:0]        RESP_DECERR = 2'b11;
  localparam logic [31:0]       UNMAPPED_DATA = 32'hDEAD_BEEF;

  typedef enum logic [1:0] {W_IDLE, W_HAVE_AW, W_HAVE_W, W_RESP} wr_state_e;
  typedef enum logic       {R_IDLE, R_RESP} rd_state_e;

  // Word index of the decoded offset; the two byte-lane bits are dropped.
  function automatic logic [WORD_W-1:0] word_of(input logic [ADDR_W-1:0] addr);
    logic [ADDR_W-1:0] off;
    off = addr & ADDR_MASK;
    return WORD_W'(off >> 2);
  endfunction

  // Write channel state
  wr_state_e                    wr_state_q, wr_state_d;
  logic                         awready_q, awready_d;
  logic                         wready_q, wready_d;
  logic                         bvalid_q, bvalid_d;
  logic [1:0]                   bresp_q, bresp_d;
  logic [ADDR_W-1:0]            aw_addr_q, aw_addr_d;
  logic [31:0]                  w_data_q, w_data_d;
  logic [NUM_CTRL-1:0][31:0]    ctrl_q, ctrl_d;
  logic [NUM_CTRL-1:0]          pulse_q, pulse_d;

  // Read channel state
  rd_state_e                    rd_state_q, rd_state_d;
  logic                         arready_q, arready_d;
  logic                         rvalid_q, rvalid_d;
  logic [31:0]                  rdata_q, rdata_d;
  logic [1:0]                   rresp_q, rresp_d;

  logic                         aw_hs, w_hs, ar_hs;
  logic                         commit;
  logic [ADDR_W-1:0]            cm_addr;
  logic [31:0]                  cm_data;
  logic [WORD_W-1:0]            wr_word, rd_word;

  assign aw_hs = s_axil.awvalid & awready_q;
  assign w_hs  = s_axil.wvalid  & wready_q;
  assign ar_hs = s_axil.arvalid & arready_q;

  // Write channel: collect AW and W in either order, commit on the second.
  always_comb begin
    wr_state_d = wr_state_q;
    awready_d  = awready_q;
    wready_d   = wready_q;
    bvalid_d   = bvalid_q;
    bresp_d    = bresp_q;
    aw_addr_d  = aw_addr_q;
    w_data_d   = w_data_q;
    ctrl_d     = ctrl_q;
    pulse_d    = '0;
    commit     = 1'b0;
    cm_addr    = aw_addr_q;
    cm_data    = w_data_q;
    wr_word    = '0;

    case (wr_state_q)
      W_IDLE: begin
        if (aw_hs && w_hs) begin
          commit  = 1'b1;
          cm_addr = s_axil.awaddr;
          cm_data = s_axil.wdata;
        end else if (aw_hs) begin
          aw_addr_d  = s_axil.awaddr;
          wr_state_d = W_HAVE_AW;
        end else if (w_hs) begin
          w_data_d   = s_axil.wdata;
          wr_state_d = W_HAVE_W;
        end
      end
      W_HAVE_AW: begin
        if (w_hs) begin
          commit  = 1'b1;
          cm_data = s_axil.wdata;
        end
      end
      W_HAVE_W: begin
        if (aw_hs) begin
          commit  = 1'b1;
          cm_addr = s_axil.awaddr;
        end
      end
      W_RESP: begin
        if (s_axil.bready) begin
          bvalid_d   = 1'b0;
          wr_state_d = W_IDLE;
        end
      end
      default: wr_state_d = W_IDLE;
    endcase

    if (commit) begin
      wr_state_d = W_RESP;
      bvalid_d   = 1'b1;
      wr_word    = word_of(cm_addr);
      if (wr_word < CTRL_WORDS) begin
        bresp_d = RESP_OKAY;
        for (int i = 0; i < int'(NUM_CTRL); i++) begin
          if (wr_word == WORD_W'(i)) begin
            ctrl_d[i]  = cm_data;
            pulse_d[i] = 1'b1;
          end
        end
      end else if (wr_word >= STAT_LO && wr_word < STAT_HI) begin
        bresp_d = RESP_SLVERR;
      end else begin
        bresp_d = RESP_DECERR;
      end
    end

    // Readies follow the state being entered so they appear with it.
    awready_d = (wr_state_d == W_IDLE) || (wr_state_d == W_HAVE_W);
    wready_d  = (wr_state_d == W_IDLE) || (wr_state_d == W_HAVE_AW);
  end

  // Read channel: register the response on the AR handshake, hold until rready.
  always_comb begin
    rd_state_d = rd_state_q;
    arready_d  = arready_q;
    rvalid_d   = rvalid_q;
    rdata_d    = rdata_q;
    rresp_d    = rresp_q;
    rd_word    = word_of(s_axil.araddr);

    case (rd_state_q)
      R_IDLE: begin
        if (ar_hs) begin
          rd_state_d = R_RESP;
          rvalid_d   = 1'b1;
          rdata_d    = UNMAPPED_DATA;
          rresp_d    = RESP_DECERR;
          if (rd_word < CTRL_WORDS) begin
            rresp_d = RESP_OKAY;
            rdata_d = '0;
            // ctrl_q is the pre-commit value when a write lands on this edge.
            for (int i = 0; i < int'(NUM_CTRL); i++) begin
              if (rd_word == WORD_W'(i)) rdata_d = ctrl_q[i];
            end
          end else if (rd_word >= STAT_LO && rd_word < STAT_HI) begin
            rresp_d = RESP_OKAY;
            rdata_d = '0;
            for (int j = 0; j < int'(NUM_STAT); j++) begin
              if (rd_word == STAT_LO + WORD_W'(j)) rdata_d = stat_in[32*j +: 32];
            end
          end
        end
      end
      R_RESP: begin
        if (s_axil.rready) begin
          rvalid_d   = 1'b0;
          rd_state_d = R_IDLE;
        end
      end
      default: rd_state_d = R_IDLE;
    endcase

    arready_d = (rd_state_d == R_IDLE);
  end

  // State and output registers
  always_ff @(posedge axil_aclk) begin
    if (!axil_aresetn) begin
      wr_state_q <= W_IDLE;
      awready_q  <= 1'b0;
      wready_q   <= 1'b0;
      bvalid_q   <= 1'b0;
      bresp_q    <= '0;
      aw_addr_q  <= '0;
      w_data_q   <= '0;
      ctrl_q     <= '0;
      pulse_q    <= '0;
      rd_state_q <= R_IDLE;
      arready_q  <= 1'b0;
      rvalid_q   <= 1'b0;
      rdata_q    <= '0;
      rresp_q    <= '0;
    end else begin
      wr_state_q <= wr_state_d;
      awready_q  <= awready_d;
      wready_q   <= wready_d;
      bvalid_q   <= bvalid_d;
      bresp_q    <= bresp_d;
      aw_addr_q  <= aw_addr_d;
      w_data_q   <= w_data_d;
      ctrl_q     <= ctrl_d;
      pulse_q    <= pulse_d;
      rd_state_q <= rd_state_d;
      arready_q  <= arready_d;
      rvalid_q   <= rvalid_d;
      rdata_q    <= rdata_d;
      rresp_q    <= rresp_d;
    end
  end

  assign s_axil.awready = awready_q;
  assign s_axil.wready  = wready_q;
  assign s_axil.bvalid  = bvalid_q;
  assign s_axil.bresp   = bresp_q;
  assign s_axil.arready = arready_q;
  assign s_axil.rvalid  = rvalid_q;
  assign s_axil.rdata   = rdata_q;
  assign s_axil.rresp   = rresp_q;
  assign ctrl_regs      = ctrl_q;
  assign ctrl_wr_pulse  = pulse_q;

endmodule
